// File: rtl/axi_node_pkg.sv
// ============================================================================
// Module : axi_node_pkg
// Brief  : Shared AXI node types: response codes and error-responder states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi_node_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SEND  = 2'd2
  } err_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_ar_error_responder.sv
// ============================================================================
// Module : axi_ar_error_responder
// Brief  : Returns ARLEN+1 DECERR beats for a read that missed every region.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_ar_error_responder
  import axi_node_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_ardata_info_i,
  input  logic [AXI_ID_WIDTH-1:0]   arid_i,
  input  logic [7:0]                arlen_i,
  input  logic [AXI_USER_WIDTH-1:0] aruser_i,
  input  logic                      outstanding_trans_i,
  output logic                      rvalid_o,
  input  logic                      rready_i,
  output logic [AXI_ID_WIDTH-1:0]   rid_o,
  output logic [AXI_DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]                rresp_o,
  output logic                      rlast_o,
  output logic [AXI_USER_WIDTH-1:0] ruser_o,
  output logic                      error_gnt_o,
  output logic                      busy_o
);

  err_state_e                r_state;
  logic [7:0]                r_cnt;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_USER_WIDTH-1:0] r_user;

  logic w_last;
  assign w_last = (r_cnt == 8'd0);

  // Strobes outside IDLE fall through untouched, so latched info is stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_id    <= '0;
      r_user  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sample_ardata_info_i) begin
            r_id    <= arid_i;
            r_user  <= aruser_i;
            r_cnt   <= arlen_i;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!outstanding_trans_i) begin
            r_state <= SEND;
          end
        end
        SEND: begin
          if (rready_i) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rvalid_o    = (r_state == SEND);
  assign rlast_o     = (r_state == SEND) && w_last;
  assign busy_o      = (r_state != IDLE);
  assign error_gnt_o = (r_state == SEND) && w_last && rready_i;
  assign rid_o       = r_id;
  assign ruser_o     = r_user;
  assign rdata_o     = '0;
  assign rresp_o     = RESP_DECERR;

endmodule

`default_nettype wire

// File: tb/tb_axi_ar_error_responder.sv
// ============================================================================
// Module : tb_axi_ar_error_responder
// Brief  : Directed self-checking bench for the AR decode-error responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_ar_error_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample;
  logic [5:0]  arid;
  logic [7:0]  arlen;
  logic [5:0]  aruser;
  logic        outstanding;
  logic        rready;
  logic        rvalid_o;
  logic [5:0]  rid_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic [5:0]  ruser_o;
  logic        error_gnt_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_ar_error_responder #(
    .AXI_ID_WIDTH  (6),
    .AXI_DATA_WIDTH(64),
    .AXI_USER_WIDTH(6)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sample_ardata_info_i(sample),
    .arid_i              (arid),
    .arlen_i             (arlen),
    .aruser_i            (aruser),
    .outstanding_trans_i (outstanding),
    .rvalid_o            (rvalid_o),
    .rready_i            (rready),
    .rid_o               (rid_o),
    .rdata_o             (rdata_o),
    .rresp_o             (rresp_o),
    .rlast_o             (rlast_o),
    .ruser_o             (ruser_o),
    .error_gnt_o         (error_gnt_o),
    .busy_o              (busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are read here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_sample(input logic [5:0] id, input logic [7:0] len, input logic [5:0] user);
    sample = 1'b1;
    arid   = id;
    arlen  = len;
    aruser = user;
    tick();
    sample = 1'b0;
    arid   = '0;
    arlen  = '0;
    aruser = '0;
  endtask

  initial begin
    int  hs;
    bit  done;
    int  beats;
    rst = 1'b1; sample = 1'b0; arid = '0; arlen = '0; aruser = '0;
    outstanding = 1'b0; rready = 1'b0;
    tick(); tick();

    // Reset state
    settle();
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_rlast",  64'(rlast_o), 64'd0);
    check("rst_gnt",    64'(error_gnt_o), 64'd0);
    check("rst_busy",   64'(busy_o), 64'd0);
    check("rst_rid",    64'(rid_o), 64'd0);
    check("rst_ruser",  64'(ruser_o), 64'd0);
    check("rst_rresp",  64'(rresp_o), 64'd3);
    check("rst_rdata",  rdata_o, 64'd0);
    rst = 1'b0;
    tick();

    // arlen 3, rready high: beats at N+2..N+5
    rready = 1'b1;
    do_sample(6'h2A, 8'd3, 6'h15);
    settle();
    check("t1_drain_rvalid", 64'(rvalid_o), 64'd0);
    check("t1_drain_busy",   64'(busy_o), 64'd1);
    for (int b = 0; b < 4; b++) begin
      tick(); settle();
      check("t1_rvalid", 64'(rvalid_o), 64'd1);
      check("t1_rid",    64'(rid_o), 64'h2A);
      check("t1_ruser",  64'(ruser_o), 64'h15);
      check("t1_rresp",  64'(rresp_o), 64'd3);
      check("t1_rlast",  64'(rlast_o), 64'(b == 3));
      check("t1_gnt",    64'(error_gnt_o), 64'(b == 3));
    end
    tick(); settle();
    check("t1_end_rvalid", 64'(rvalid_o), 64'd0);
    check("t1_end_busy",   64'(busy_o), 64'd0);
    check("t1_end_gnt",    64'(error_gnt_o), 64'd0);

    // arlen 0 with 3 stall cycles
    rready = 1'b0;
    do_sample(6'h07, 8'd0, 6'h01);
    tick();
    for (int s = 0; s < 3; s++) begin
      settle();
      check("t2_stall_rvalid", 64'(rvalid_o), 64'd1);
      check("t2_stall_rlast",  64'(rlast_o), 64'd1);
      check("t2_stall_rid",    64'(rid_o), 64'h07);
      check("t2_stall_gnt",    64'(error_gnt_o), 64'd0);
      tick();
    end
    rready = 1'b1;
    settle();
    check("t2_hs_gnt",   64'(error_gnt_o), 64'd1);
    check("t2_hs_rlast", 64'(rlast_o), 64'd1);
    tick(); settle();
    check("t2_end_busy", 64'(busy_o), 64'd0);

    // outstanding high for 10 cycles after the sample
    outstanding = 1'b1;
    do_sample(6'h09, 8'd0, 6'h02);
    for (int c = 0; c < 10; c++) begin
      settle();
      check("t3_wait_rvalid", 64'(rvalid_o), 64'd0);
      check("t3_wait_busy",   64'(busy_o), 64'd1);
      tick();
    end
    outstanding = 1'b0;
    settle();
    check("t3_drop_rvalid", 64'(rvalid_o), 64'd0);
    tick(); settle();
    check("t3_first_rvalid", 64'(rvalid_o), 64'd1);
    check("t3_first_gnt",    64'(error_gnt_o), 64'd1);
    tick(); settle();
    check("t3_end_busy", 64'(busy_o), 64'd0);

    // arlen 255 with rready toggling 1010...
    do_sample(6'h3F, 8'd255, 6'h3F);
    tick();
    hs = 0;
    done = 1'b0;
    for (int c = 0; c < 1200 && !done; c++) begin
      rready = (c % 2 == 0);
      settle();
      if (!rvalid_o) begin
        check("t4_rvalid_held", 64'(rvalid_o), 64'd1);
        done = 1'b1;
      end else if (rready) begin
        hs++;
        check("t4_rlast", 64'(rlast_o), 64'(hs == 256));
        check("t4_gnt",   64'(error_gnt_o), 64'(hs == 256));
        if (hs == 256) done = 1'b1;
      end
      tick();
    end
    check("t4_handshakes", 64'(hs), 64'd256);
    settle();
    check("t4_end_busy", 64'(busy_o), 64'd0);

    // Strobes mid-SEND and on the grant cycle are both ignored
    rready = 1'b1;
    do_sample(6'h2A, 8'd3, 6'h0C);
    tick();
    beats = 0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      sample = (c == 1) || (c == 3);
      arid   = 6'h11;
      arlen  = 8'd7;
      aruser = 6'h22;
      settle();
      if (rvalid_o) beats++;
      check("t5_rid",   64'(rid_o), 64'h2A);
      check("t5_ruser", 64'(ruser_o), 64'h0C);
      if (error_gnt_o) done = 1'b1;
      tick();
    end
    sample = 1'b0;
    check("t5_beats", 64'(beats), 64'd4);
    settle();
    check("t5_end_busy",   64'(busy_o), 64'd0);
    check("t5_end_rvalid", 64'(rvalid_o), 64'd0);

    // Reset during beat 2 of 4, then a fresh burst
    do_sample(6'h05, 8'd3, 6'h05);
    tick(); tick();
    settle();
    check("t6_beat2_rvalid", 64'(rvalid_o), 64'd1);
    rst = 1'b1;
    settle();
    check("t6_beat2_gnt", 64'(error_gnt_o), 64'd0);
    tick();
    rst = 1'b0;
    settle();
    check("t6_rst_rvalid", 64'(rvalid_o), 64'd0);
    check("t6_rst_busy",   64'(busy_o), 64'd0);
    check("t6_rst_gnt",    64'(error_gnt_o), 64'd0);
    do_sample(6'h33, 8'd1, 6'h11);
    tick();
    for (int b = 0; b < 2; b++) begin
      settle();
      check("t6_rvalid", 64'(rvalid_o), 64'd1);
      check("t6_rid",    64'(rid_o), 64'h33);
      check("t6_rlast",  64'(rlast_o), 64'(b == 1));
      check("t6_gnt",    64'(error_gnt_o), 64'(b == 1));
      tick();
    end
    settle();
    check("t6_end_busy", 64'(busy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_ar_error_responder.md
# axi_ar_error_responder

Generates the AXI4 read-data error response for a read request that matches no enabled slave region. It sits directly downstream of the per-target AR address decoder in the AXI node, which stalls the AR channel when it detects a decode miss.
- The decoder pulses a sample strobe while accepting the faulty request.
- This block latches ID, length and user, waits until earlier same-target reads have drained, then emits ARLEN+1 DECERR beats on the R channel.
- It returns a one-cycle grant so the decoder can leave its ERROR state.

## Interface
Parameters:
- AXI_ID_WIDTH, default 6: width of arid/rid.
- AXI_DATA_WIDTH, default 64: width of rdata.
- AXI_USER_WIDTH, default 6: width of aruser/ruser.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_ardata_info_i  input  1  one-cycle strobe from the decoder; latch AR info and arm.
- arid_i  input  AXI_ID_WIDTH  ID of the faulty request.
- arlen_i  input  8  burst length minus one.
- aruser_i  input  AXI_USER_WIDTH  user field of the faulty request.
- outstanding_trans_i  input  1  high while earlier reads to this target are still in flight.
- rvalid_o  output  1  error beat valid.
- rready_i  input  1  R-channel ready from the master side.
- rid_o  output  AXI_ID_WIDTH  latched arid.
- rdata_o  output  AXI_DATA_WIDTH  constant all-zero.
- rresp_o  output  2  constant 2'b11 (DECERR).
- rlast_o  output  1  final beat marker.
- ruser_o  output  AXI_USER_WIDTH  latched aruser.
- error_gnt_o  output  1  one-cycle pulse on final beat handshake; feeds the decoder's error grant.
- busy_o  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, DRAIN, SEND.
- IDLE:
  - When sample_ardata_info_i is high, register arid_i, aruser_i and arlen_i. arlen_i loads the beat counter.
  - Next state is DRAIN.
- DRAIN:
  - rvalid_o is low.
  - When outstanding_trans_i is low, go to SEND. Otherwise stay in DRAIN, with no timeout.
  - This wait preserves AXI same-ID ordering against responses still returning.
- SEND:
  - rvalid_o is high.
  - rlast_o equals (beat counter == 0).
  - On rvalid_o & rready_i with the counter non-zero, decrement the counter.
  - On rvalid_o & rready_i with the counter zero, assert error_gnt_o combinationally in that cycle and go to IDLE.
- Beat counter: 8-bit, unsigned.
  - arlen 0 gives a single beat with rlast_o set.
  - arlen 255 gives 256 beats.
  - No wrap-around: the counter is never decremented at zero.
- rid_o and ruser_o hold their latched values from the sample until the next sample. rresp_o and rdata_o are constant.
- sample_ardata_info_i while busy_o is high is ignored; the latched values and state are unchanged. The decoder never issues this, but the block must tolerate it.
- outstanding_trans_i is ignored outside DRAIN. A re-assertion during SEND does not pause the beats.

## Timing
- Reset values: state IDLE, counter 0, rid_o 0, ruser_o 0. rvalid_o, rlast_o, error_gnt_o and busy_o are all 0.
- Reset mid-burst:
  - The next cycle is IDLE with rvalid_o low.
  - The burst is abandoned and no error_gnt_o is issued.
- Sample at edge N with outstanding_trans_i low gives DRAIN in cycle N+1 and SEND in cycle N+2. First rvalid_o is therefore 2 cycles after the strobe, minimum.
- rvalid_o, rlast_o and busy_o are decoded from registered state only; there is no combinational path from inputs.
- error_gnt_o is combinational from rready_i in SEND. It is high for exactly one cycle per error.
- Once asserted, rvalid_o stays high until its handshake. rid_o, rresp_o, rlast_o and ruser_o stay stable while rvalid_o & !rready_i.
- A sample strobe in the same cycle that error_gnt_o is high is ignored, because the block is still in SEND.
- Throughput: one beat per cycle with rready_i held high.

## Structure
- Put the state enum (IDLE/DRAIN/SEND) and the RESP_DECERR = 2'b11 constant in the shared axi_node package, next to the other AXI response codes.
- Single flat module; no sub-module is warranted.
- The beat counter and the latch registers are plain always_ff logic.

## Test plan
- Sample with arid 0x2A, arlen 3, outstanding low, rready held high -> rvalid high for cycles N+2..N+5, rid 0x2A and rresp 2'b11 every beat, rlast only at N+5, error_gnt one pulse at N+5.
- arlen 0, with rready low for 3 cycles then high -> single beat with rlast held stable while stalled, then error_gnt on the handshake cycle, then busy low next cycle.
- outstanding_trans_i high for 10 cycles after the sample -> rvalid stays low throughout. First beat comes 1 cycle after outstanding drops.
- arlen 255, rready toggling 1010... -> exactly 256 handshakes, rlast only on the 256th, no counter wrap.
- Second sample strobe in mid-SEND with arid 0x11 -> ignored; rid stays 0x2A and the beat count is unchanged.
- rst asserted during beat 2 of 4 -> rvalid low and busy low next cycle, no error_gnt. A fresh sample afterwards completes normally.
